// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, a small {pc, inst} queue toward decode,
// and redirect handling that drains an in-flight memory request before refetching.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     drop_addr_q, drop_addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t          fifo_q [QDEPTH];
    logic            push;
    logic            pop;

    // Request side: decoded from state only; held low while reset is asserted.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (!rst) begin
            case (state_q)
                RUN:  imem_req = (count_q < CW'(QDEPTH));
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = drop_addr_q;
                end
                default: imem_req = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (redirect) begin
            // Flush; an unacked RUN request must still be drained in DROP.
            pc_d     = redirect_pc & ~32'h0000_0003;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            case (state_q)
                RUN: begin
                    if (imem_req && !imem_ack) begin
                        state_d     = DROP;
                        drop_addr_d = imem_addr;
                    end
                end
                DROP: begin
                    if (imem_ack) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end else begin
            case (state_q)
                RUN:  push = imem_req && imem_ack;
                DROP: begin
                    if (imem_ack) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
            pop = (count_q != '0) && out_ready;

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pc_d     = pc_q + 32'd4;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            if (push) fifo_q[wr_ptr_q] <= '{pc: pc_q, inst: imem_data};
        end
    end

    // Head entry is driven straight from storage registers.
    assign out_valid = (count_q != '0);
    assign out_pc    = fifo_q[rd_ptr_q].pc;
    assign out_inst  = fifo_q[rd_ptr_q].inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for streaming/backpressure/redirect,
// plus hand sequences for redirect-while-stalled and reset-during-drop.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_ready   (out_ready)
    );

    function automatic logic [31:0] minst(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_data = minst(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t v(input logic r, input logic a, input logic rd, input logic rx,
                               input logic [31:0] rp, input logic eq, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep);
        vec_t t;
        t.rst = r; t.ack = a; t.rdy = rd; t.redir = rx; t.rpc = rp;
        t.e_req = eq; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic rd, input logic rx,
                        input logic [31:0] rp);
        rst = r; imem_ack = a; out_ready = rd; redirect = rx; redirect_pc = rp;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; imem_ack = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Streaming from reset with ack and ready every cycle.
        tbl.push_back(v(1, 1, 1, 0, 0,            0, 32'h0,          0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h0,          0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h4,          1, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h8,          1, 32'h4));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'hC,          1, 32'h8));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h10,         1, 32'hC));
        // Backpressure: queue fills, then one pop frees one slot.
        tbl.push_back(v(1, 1, 0, 0, 0,            0, 32'h0,          0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 0,            1, 32'h0,          0, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 0,            1, 32'h4,          1, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 0,            0, 32'h0,          1, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            0, 32'h0,          1, 32'h0));
        tbl.push_back(v(0, 1, 0, 0, 0,            1, 32'h8,          1, 32'h4));
        tbl.push_back(v(0, 1, 0, 0, 0,            0, 32'h0,          1, 32'h4));
        // Redirect to 0x100 while the request at 0x8 is acked.
        tbl.push_back(v(1, 1, 1, 0, 0,            0, 32'h0,          0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h0,          0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h4,          1, 32'h0));
        tbl.push_back(v(0, 1, 1, 1, 32'h100,      1, 32'h8,          1, 32'h4));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h100,        0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h104,        1, 32'h100));
        // Unaligned redirect near the top of memory, then PC wrap.
        tbl.push_back(v(0, 1, 1, 1, 32'hFFFF_FFFE, 1, 32'h108,       1, 32'h104));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'hFFFF_FFFC,  0, 32'h0));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h0,          1, 32'hFFFF_FFFC));
        tbl.push_back(v(0, 1, 1, 0, 0,            1, 32'h4,          1, 32'h0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("v%0d.req", i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("v%0d.addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d.pc", i), out_pc, tbl[i].e_pc);
                chk($sformatf("v%0d.inst", i), out_inst, minst(tbl[i].e_pc));
            end
            if (tbl[i].rst) begin
                chk($sformatf("v%0d.rst_pc", i), out_pc, 32'h0);
                chk($sformatf("v%0d.rst_inst", i), out_inst, 32'h0);
            end
            adv();
        end

        // Redirect to 0x200 while the request at 0xC is stalled.
        step(1, 1, 1, 0, 0); adv();
        step(0, 1, 1, 0, 0); adv();
        step(0, 1, 1, 0, 0); adv();
        step(0, 1, 1, 0, 0); adv();
        step(0, 0, 1, 1, 32'h200);
        chk("stall.addr", imem_addr, 32'hC);
        chk("stall.pc", out_pc, 32'h8);
        adv();
        step(0, 0, 1, 0, 0);
        chk("drop.req", 32'(imem_req), 32'd1);
        chk("drop.addr", imem_addr, 32'hC);
        chk("drop.valid", 32'(out_valid), 32'd0);
        adv();
        step(0, 1, 1, 0, 0);
        chk("drop.addr_held", imem_addr, 32'hC);
        adv();
        step(0, 1, 1, 0, 0);
        chk("post_drop.addr", imem_addr, 32'h200);
        chk("post_drop.valid", 32'(out_valid), 32'd0);
        adv();
        step(0, 0, 1, 0, 0);
        chk("tgt.valid", 32'(out_valid), 32'd1);
        chk("tgt.pc", out_pc, 32'h200);
        chk("tgt.inst", out_inst, minst(32'h200));
        chk("tgt.next_addr", imem_addr, 32'h204);
        adv();

        // Enter DROP, then reset with ack held low.
        step(0, 0, 1, 1, 32'h40); adv();
        step(0, 0, 1, 0, 0);
        chk("drop2.addr", imem_addr, 32'h204);
        adv();
        step(1, 0, 1, 0, 0);
        chk("rst_drop.req", 32'(imem_req), 32'd0);
        chk("rst_drop.valid", 32'(out_valid), 32'd0);
        chk("rst_drop.pc", out_pc, 32'h0);
        adv();
        step(0, 0, 1, 0, 0);
        chk("rel.req", 32'(imem_req), 32'd1);
        chk("rel.addr", imem_addr, 32'h0);
        chk("rel.valid", 32'(out_valid), 32'd0);
        adv();
        step(0, 0, 1, 0, 0);
        chk("rel.valid_wait", 32'(out_valid), 32'd0);
        adv();
        step(0, 1, 1, 0, 0); adv();
        step(0, 0, 1, 0, 0);
        chk("rel.first_valid", 32'(out_valid), 32'd1);
        chk("rel.first_pc", out_pc, 32'h0);
        chk("rel.first_inst", out_inst, minst(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter QDEPTH, default 2: instruction queue depth in entries; legal values are powers of two, 2 or greater.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned read address, valid while imem_req=1.
REQ-007 imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-008 imem_data  input  32  instruction word, valid only when imem_req=1 and imem_ack=1.
REQ-009 redirect  input  1  branch/jump taken: refetch from redirect_pc.
REQ-010 redirect_pc  input  32  target address; bits [1:0] are ignored and treated as 0.
REQ-011 out_valid  output  1  queue head holds an instruction for the decoder.
REQ-012 out_inst  output  32  queue-head instruction word, fed to the decoder's inst input.
REQ-013 out_pc  output  32  address of out_inst.
REQ-014 out_ready  input  1  decoder consumes the head entry this cycle.

Function
REQ-015 The block SHALL hold fetch PC (32 bits), a QDEPTH-entry FIFO of {pc, inst}, an occupancy count (0..QDEPTH), a 2-state FSM {RUN, DROP}, and a 32-bit drop_addr.
REQ-016 RUN: imem_req SHALL be 1 exactly when count < QDEPTH, with imem_addr = PC.
REQ-017 DROP: imem_req SHALL be 1 and imem_addr = drop_addr, both held stable until imem_ack.
REQ-018 The address SHALL never change while imem_req=1 and imem_ack=0, except through the RUN->DROP transition in REQ-021, which preserves it.
REQ-019 RUN with imem_req=1 and imem_ack=1 and redirect=0: push {PC, imem_data} and set PC <= PC+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
REQ-020 Pop on out_valid=1 and out_ready=1; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 redirect=1 in any state: flush the FIFO (count <= 0), ignore any push/pop in that cycle, and set PC <= {redirect_pc[31:2], 2'b00}.
REQ-022 For REQ-021: if RUN with imem_req=1 and imem_ack=0, go to DROP with drop_addr <= current imem_addr; otherwise stay in or enter RUN.
REQ-023 DROP with imem_ack=1 SHALL discard imem_data and go to RUN; a redirect in that cycle only updates PC.
REQ-024 DROP SHALL never push; pops proceed normally, but the FIFO is empty since the flush.
REQ-025 out_valid = (count != 0); out_inst/out_pc SHALL come directly from the head entry registers, with no combinational path from imem_data.
REQ-026 Fetch-to-decode latency SHALL be 1 cycle: data acked in cycle N is visible on out_* in cycle N+1.
REQ-027 With continuous ack and out_ready=1, throughput SHALL be one instruction per cycle.
REQ-028 Data acked in a redirect cycle SHALL never reach out_*.

Reset
REQ-029 While rst=1, asynchronously: PC=RESET_PC, count=0, FSM=RUN, drop_addr=0, out_valid=0, imem_req=0, out_inst=0, out_pc=0.
REQ-030 First cycle after rst falls: imem_req=1, imem_addr=RESET_PC.
REQ-031 Reset asserted mid-request or in DROP SHALL abandon the request without a pending state; no imem_ack is required to recover.

Verification
REQ-032 Reset release, ack every cycle, out_ready=1 -> out_pc = 0,4,8,... from cycle 2; out_inst equals the memory words in order; no gaps.
REQ-033 out_ready=0, ack always 1 -> after 2 pushes imem_req=0 and out_pc stays 0x0; out_ready=1 for 1 cycle -> out_pc=0x4 and one new request at 0x8.
REQ-034 redirect=1 with redirect_pc=0x100 while ack=1 at PC 0x8 -> FIFO flushed, that word discarded, next request at 0x100, next out_pc=0x100.
REQ-035 redirect to 0x200 while request at 0xC has ack=0 -> imem_addr stays 0xC until ack, word discarded, then request at 0x200.
REQ-036 redirect_pc=0xFFFF_FFFE -> fetch at 0xFFFF_FFFC, then 0x0000_0000 (wrap).
REQ-037 rst pulsed in DROP with ack held 0 -> after release, request at RESET_PC, out_valid=0 until its ack.
